quad_decoder: RTL and testbench
===============================

Name: quad_decoder

Overview:
Quadrature decoder front end for the up/down binary counter: it produces the counter's enable/direction strobes.
- Synchronises and glitch-filters incremental encoder channels A/B.
- Decodes Gray-code transitions at x1/x2/x4 resolution.
- Emits one-cycle count strobes with direction.
- Flags illegal double-bit transitions.

Parameters:
FILT_N, 4, consecutive stable cycles a synchronised input must hold before the filtered value changes (≥1)
FW, $clog2(FILT_N+1), filter counter width (localparam, derived)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  decode enable; 0 suppresses strobes and error detection
a_in  input  1  encoder channel A, asynchronous
b_in  input  1  encoder channel B, asynchronous
res  input  2  resolution: 00 x1, 01 x2, 10 x4, 11 treated as x4
err_clr  input  1  clears sticky error
cnt_en  output  1  one-cycle count strobe (feeds counter en)
cnt_up  output  1  direction, valid when cnt_en=1 (feeds counter up)
err  output  1  sticky illegal-transition flag
state_ab  output  2  filtered {A,B}

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. All flops clear on rst_n=0.
- Reset values: cnt_en=0, cnt_up=0, err=0, state_ab=00, sync flops 0, filter counters 0, FSM=WARM0.
- Synchroniser: two flops per channel (sync1, sync2).
- Glitch filter, per channel:
  - If sync2==filt: counter <= 0.
  - Else if counter==FILT_N-1: filt <= sync2, counter <= 0.
  - Else: counter increments.
  - A reversal before FILT_N cycles discards the change.
- FSM states: WARM0 -> WARM1 -> WARM2 -> RUN, advancing one state per clock.
  - In WARM2, filt and prev load sync2 directly. No strobes, no errors.
  - RUN persists until reset. Asserting rst_n mid-operation restarts from WARM0.
- Decode (RUN only): prev <= filt every cycle, regardless of en. Transition prev->filt is classified as:
  - Forward (cnt_up=1): 00->01->11->10->00.
  - Reverse (cnt_up=0): the opposite order.
  - Illegal (00<->11, 01<->10): err <= 1, no strobe.
- Resolution gating:
  - x4: every legal transition strobes.
  - x1: only 10->00 (up) and 00->10 (down) strobe.
  - x2: x1 set plus 01->11 (up) and 11->01 (down).
  - res is sampled combinationally at the decode cycle.
- Output timing: cnt_en and cnt_up are registered and strobe in the cycle after filt changes.
  - Pin change captured at edge 1 -> filt changes at edge FILT_N+2 -> cnt_en high after edge FILT_N+3, for exactly one cycle.
  - cnt_up holds its last value while cnt_en=0.
- en=0: no strobes, no error set; prev still tracks filt, so re-enabling produces no stale event.
- err: sticky. err_clr=1 clears it. A new error in the same cycle as err_clr wins (err=1).
- Strobe rate: at most one strobe per FILT_N cycles per channel. The downstream counter needs no handshake.

Decomposition:
- Package quad_pkg:
  - res encodings RES_X1/RES_X2/RES_X4.
  - FSM state localparams WARM0/WARM1/WARM2/RUN (2-bit).
- Sub-module quad_glitch_filter (synchroniser + stability filter, parameter FILT_N), instantiated once per channel.
- Top level holds FSM, transition decoder, resolution gating, output registers.

Test Plan:
1. Hold a_in=1, b_in=1 through reset, release -> state_ab=11 after edge 3; cnt_en never pulses; err=0.
2. FILT_N=4, res=10, forward 00->01->11->10->00, each held 10 cycles -> 4 cnt_en pulses, cnt_up=1; first pulse high after edge 7 from the pin change.
3. res=00, reverse sequence 00->10->11->01->00 -> exactly one pulse, at 00->10, cnt_up=0. res=01 on the same sequence -> two pulses, both cnt_up=0.
4. FILT_N=4, a_in high for 3 cycles then low -> no state_ab change, no pulse. High for 4 cycles -> state_ab changes, one pulse.
5. a_in and b_in flip together 00->11 -> err=1, no cnt_en. err_clr for one cycle -> err=0. err_clr coincident with another 11->00 flip -> err stays 1.
6. en=0 during a full forward cycle, then en=1 with no input change -> zero pulses and err=0 throughout. Next forward step -> exactly one pulse.

Source files
------------

// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared encodings for the quadrature decoder slice
package quad_pkg;

  localparam logic [1:0] RES_X1 = 2'b00;
  localparam logic [1:0] RES_X2 = 2'b01;
  localparam logic [1:0] RES_X4 = 2'b10;

  typedef enum logic [1:0] {
    WARM0 = 2'd0,
    WARM1 = 2'd1,
    WARM2 = 2'd2,
    RUN   = 2'd3
  } quad_state_e;

  // Position of a filtered {A,B} pair along the forward Gray cycle 00-01-11-10.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    logic [1:0] pos;
    case (ab)
      2'b00:   pos = 2'd0;
      2'b01:   pos = 2'd1;
      2'b11:   pos = 2'd2;
      default: pos = 2'd3;
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// rtl/quad_glitch_filter.sv - two-flop synchroniser plus stability filter for one encoder channel
module quad_glitch_filter #(
  parameter int FILT_N = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load_i,
  input  logic din_i,
  output logic sync_o,
  output logic filt_o
);

  localparam int FW = $clog2(FILT_N + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          filt_q;
  logic          filt_d;
  logic [FW-1:0] cnt_q;
  logic [FW-1:0] cnt_d;

  // load_i seeds the filter straight from the synchroniser during warm-up.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == FW'(FILT_N - 1)) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + FW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync_o = sync2_q;
  assign filt_o = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature decoder producing count strobes, direction and sticky error
module quad_decoder
  import quad_pkg::*;
#(
  parameter int FILT_N = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       a_in,
  input  logic       b_in,
  input  logic [1:0] res,
  input  logic       err_clr,
  output logic       cnt_en,
  output logic       cnt_up,
  output logic       err,
  output logic [1:0] state_ab
);

  quad_state_e state_q;
  quad_state_e state_d;
  logic        load;
  logic        run;

  logic        sync_a;
  logic        sync_b;
  logic        filt_a;
  logic        filt_b;
  logic [1:0]  filt;

  logic [1:0]  prev_q;
  logic [1:0]  prev_d;
  logic [1:0]  step;
  logic        fwd;
  logic        rev;
  logic        illegal;
  logic        hit;
  logic        strobe;

  logic        cnt_en_q;
  logic        cnt_en_d;
  logic        cnt_up_q;
  logic        cnt_up_d;
  logic        err_q;
  logic        err_d;

  quad_glitch_filter #(.FILT_N(FILT_N)) u_filt_a (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .load_i  (load),
    .din_i   (a_in),
    .sync_o  (sync_a),
    .filt_o  (filt_a)
  );

  quad_glitch_filter #(.FILT_N(FILT_N)) u_filt_b (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .load_i  (load),
    .din_i   (b_in),
    .sync_o  (sync_b),
    .filt_o  (filt_b)
  );

  assign filt = {filt_a, filt_b};

  // Warm-up lets the synchronisers fill before the first decode.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    run     = 1'b0;
    case (state_q)
      WARM0: state_d = WARM1;
      WARM1: state_d = WARM2;
      WARM2: begin
        state_d = RUN;
        load    = 1'b1;
      end
      RUN:     run = 1'b1;
      default: state_d = WARM0;
    endcase
  end

  always_comb begin
    step    = gray_pos(filt) - gray_pos(prev_q);
    fwd     = (step == 2'd1);
    rev     = (step == 2'd3);
    illegal = (step == 2'd2);
    case (res)
      RES_X1:  hit = (fwd && prev_q == 2'b10) || (rev && prev_q == 2'b00);
      RES_X2:  hit = (fwd && (prev_q == 2'b10 || prev_q == 2'b01)) ||
                     (rev && (prev_q == 2'b00 || prev_q == 2'b11));
      default: hit = fwd || rev;
    endcase
    strobe = run && en && hit;
  end

  // prev tracks filt even while disabled so re-enabling never replays an old edge.
  always_comb begin
    prev_d   = prev_q;
    if (load) begin
      prev_d = {sync_a, sync_b};
    end else if (run) begin
      prev_d = filt;
    end
    cnt_en_d = strobe;
    cnt_up_d = strobe ? fwd : cnt_up_q;
    err_d    = (err_q && !err_clr) || (run && en && illegal);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WARM0;
      prev_q   <= 2'b00;
      cnt_en_q <= 1'b0;
      cnt_up_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      cnt_en_q <= cnt_en_d;
      cnt_up_q <= cnt_up_d;
      err_q    <= err_d;
    end
  end

  assign cnt_en   = cnt_en_q;
  assign cnt_up   = cnt_up_q;
  assign err      = err_q;
  assign state_ab = filt;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - directed and random checks of quad_decoder against a pin-history model
module tb_quad_decoder;

  localparam int FILT_N = 4;
  localparam int HMAX   = 8192;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       err_clr = 1'b0;
  logic [1:0] res = 2'b10;
  logic       cnt_en;
  logic       cnt_up;
  logic       err;
  logic [1:0] state_ab;

  always #5 clk = ~clk;

  quad_decoder #(.FILT_N(FILT_N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .a_in     (a_in),
    .b_in     (b_in),
    .res      (res),
    .err_clr  (err_clr),
    .cnt_en   (cnt_en),
    .cnt_up   (cnt_up),
    .err      (err),
    .state_ab (state_ab)
  );

  int checks = 0;
  int failures = 0;
  int n = 0;
  int pulses = 0;
  int lat;
  int hold;

  bit         pa [HMAX];
  bit         pb [HMAX];
  bit         pe [HMAX];
  bit         pc [HMAX];
  logic [1:0] pr [HMAX];

  logic [1:0] mfilt, mprev;
  logic       mexp_en, mexp_up, merr;
  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int seq_idx(input logic [1:0] v);
    for (int i = 0; i < 4; i++) if (seq[i] == v) return i;
    return 0;
  endfunction

  // A filtered channel flips once its last FILT_N captured pin samples (since warm-up) all disagree with it.
  function automatic bit stable(input bit ch_a, input bit v);
    if (n - 1 - FILT_N < 2) return 1'b0;
    for (int k = n - 1 - FILT_N; k <= n - 2; k++)
      if ((ch_a ? pa[k] : pb[k]) != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    int  i;
    bit  up, dn, hit;
    logic [1:0] nf;
    merr    = merr & ~pc[n];
    mexp_en = 1'b0;
    if (n == 3) begin
      mfilt = {pa[1], pb[1]};
      mprev = mfilt;
    end else if (n >= 4) begin
      i  = seq_idx(mprev);
      up = (mfilt == seq[(i + 1) % 4]);
      dn = (mfilt == seq[(i + 3) % 4]);
      case (pr[n])
        2'b00:   hit = (up && mprev == 2'b10) || (dn && mprev == 2'b00);
        2'b01:   hit = (up && (mprev == 2'b10 || mprev == 2'b01)) ||
                       (dn && (mprev == 2'b00 || mprev == 2'b11));
        default: hit = up || dn;
      endcase
      if (pe[n] && hit) begin
        mexp_en = 1'b1;
        mexp_up = up;
      end
      if (pe[n] && mfilt != mprev && !up && !dn) merr = 1'b1;
      mprev = mfilt;
      nf = mfilt;
      if (stable(1'b1, ~mfilt[1])) nf[1] = ~mfilt[1];
      if (stable(1'b0, ~mfilt[0])) nf[0] = ~mfilt[0];
      mfilt = nf;
    end
  endtask

  task automatic tick();
    pa[n+1] = a_in;
    pb[n+1] = b_in;
    pe[n+1] = en;
    pc[n+1] = err_clr;
    pr[n+1] = res;
    @(posedge clk);
    n++;
    model_edge();
    @(negedge clk);
    check("cnt_en", cnt_en, mexp_en);
    check("cnt_up", cnt_up, mexp_up);
    check("err", err, merr);
    check("state_ab", state_ab, mfilt);
    if (cnt_en) pulses++;
  endtask

  task automatic do_reset(input bit a, input bit b);
    @(negedge clk);
    rst_n = 1'b0;
    a_in = a;
    b_in = b;
    en = 1'b1;
    err_clr = 1'b0;
    #1;
    check("rst_cnt_en", cnt_en, 0);
    check("rst_cnt_up", cnt_up, 0);
    check("rst_err", err, 0);
    check("rst_state_ab", state_ab, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    mfilt = 2'b00;
    mprev = 2'b00;
    mexp_en = 1'b0;
    mexp_up = 1'b0;
    merr = 1'b0;
    pulses = 0;
  endtask

  task automatic step_to(input logic [1:0] v, input int cycles);
    {a_in, b_in} = v;
    repeat (cycles) tick();
  endtask

  initial begin
    // Inputs held high through reset appear on state_ab once warm-up completes.
    do_reset(1'b1, 1'b1);
    repeat (3) tick();
    check("t1_state_after_edge3", state_ab, 2'b11);
    repeat (20) tick();
    check("t1_pulses", pulses, 0);
    check("t1_err", err, 0);

    // x4 forward cycle with first-pulse latency.
    do_reset(1'b0, 1'b0);
    res = 2'b10;
    repeat (10) tick();
    pulses = 0;
    {a_in, b_in} = 2'b01;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (cnt_en && lat == 0) lat = k;
    end
    check("t2_latency", lat, 7);
    step_to(2'b11, 10);
    step_to(2'b10, 10);
    step_to(2'b00, 10);
    check("t2_pulses", pulses, 4);
    check("t2_dir", cnt_up, 1);

    // x1 and x2 on the reverse cycle.
    res = 2'b00;
    pulses = 0;
    step_to(2'b10, 10); step_to(2'b11, 10); step_to(2'b01, 10); step_to(2'b00, 10);
    check("t3_x1_pulses", pulses, 1);
    check("t3_x1_dir", cnt_up, 0);
    res = 2'b01;
    pulses = 0;
    step_to(2'b10, 10); step_to(2'b11, 10); step_to(2'b01, 10); step_to(2'b00, 10);
    check("t3_x2_pulses", pulses, 2);
    check("t3_x2_dir", cnt_up, 0);

    // Filter boundary: FILT_N-1 cycles rejected, FILT_N cycles accepted.
    res = 2'b10;
    pulses = 0;
    a_in = 1'b1;
    repeat (3) tick();
    a_in = 1'b0;
    repeat (10) tick();
    check("t4_short_pulses", pulses, 0);
    check("t4_short_state", state_ab, 2'b00);
    a_in = 1'b1;
    repeat (14) tick();
    check("t4_long_pulses", pulses, 1);
    check("t4_long_state", state_ab, 2'b10);
    step_to(2'b00, 10);

    // Illegal double transitions and clear priority.
    pulses = 0;
    step_to(2'b11, 10);
    check("t5_err_set", err, 1);
    check("t5_no_pulse", pulses, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t5_err_clr", err, 0);
    repeat (3) tick();
    {a_in, b_in} = 2'b00;
    repeat (6) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t5_err_wins", err, 1);
    repeat (5) tick();
    check("t5_no_pulse2", pulses, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Disabled decode leaves no stale event behind.
    en = 1'b0;
    pulses = 0;
    step_to(2'b01, 10); step_to(2'b11, 10); step_to(2'b10, 10); step_to(2'b00, 10);
    en = 1'b1;
    repeat (10) tick();
    check("t6_disabled_pulses", pulses, 0);
    check("t6_err", err, 0);
    step_to(2'b01, 10);
    check("t6_reenabled_pulses", pulses, 1);

    // Random pins, enable, resolution and clears.
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        a_in = 1'($urandom_range(0, 1));
        b_in = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end
      hold--;
      if (c % 50 == 0) res = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 7) != 0);
      err_clr = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
